// File: rtl/spr_access_ctrl.sv
// SPR access initiator: decodes mtspr/mfspr requests onto SPR file ports and owns the DEC decrementer.
// Optional build macro SPR_PRIV_CHECK_EN adds req_priv and rejects user-mode access to privileged SPRs.
module spr_access_ctrl #(
  parameter int DATA_W       = 32,
  parameter int IDX_W        = 4,
  parameter int DEC_PRESCALE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_mt,
  input  logic [9:0]        req_sprn,
  input  logic [DATA_W-1:0] req_wdata,
`ifdef SPR_PRIV_CHECK_EN
  input  logic              req_priv,
`endif
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              spr_wr0,
  output logic [IDX_W-1:0]  spr_waddr0,
  output logic [DATA_W-1:0] spr_wd0,
  output logic [IDX_W-1:0]  spr_raddr0,
  input  logic [DATA_W-1:0] spr_rd0,
  output logic              spr_wr1,
  output logic [IDX_W-1:0]  spr_waddr1,
  output logic [DATA_W-1:0] spr_wd1,
  output logic              dec_irq
);

  localparam logic [IDX_W-1:0] DEC_IDX = IDX_W'(3);
  localparam int PRE_W = (DEC_PRESCALE > 1) ? $clog2(DEC_PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DEC_PRESCALE - 1);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  // Handshakes: a transfer happens on a rising clk edge where valid & ready are both 1;
  // the sender holds valid and its payload stable until that edge.
  state_t state, state_nx;

  logic [9:0]        sprn;
  logic [IDX_W-1:0]  dec_idx_c;
  logic              dec_legal_c;
  logic              req_fire;

  logic              mt_q;
  logic              legal_q;
  logic              is_dec_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_err_q;

  logic [PRE_W-1:0]  pre_cnt;
  logic [DATA_W-1:0] dec_cnt;
  logic              tick;
  logic              dec_load;
  logic              irq_q;
  logic              wr1_q;
  logic [DATA_W-1:0] wd1_q;

  // The instruction field carries the two 5-bit halves of the SPR number swapped.
  assign sprn     = {req_sprn[4:0], req_sprn[9:5]};
  assign req_fire = req_valid & req_ready;

  always_comb begin
    dec_idx_c   = '0;
    dec_legal_c = 1'b1;
    case (sprn)
      10'd1:   dec_idx_c = IDX_W'(0);
      10'd8:   dec_idx_c = IDX_W'(1);
      10'd9:   dec_idx_c = IDX_W'(2);
      10'd22:  dec_idx_c = DEC_IDX;
      10'd26:  dec_idx_c = IDX_W'(4);
      10'd27:  dec_idx_c = IDX_W'(5);
      10'd272: dec_idx_c = IDX_W'(6);
      10'd273: dec_idx_c = IDX_W'(7);
      10'd274: dec_idx_c = IDX_W'(8);
      10'd275: dec_idx_c = IDX_W'(9);
      default: dec_legal_c = 1'b0;
    endcase
`ifdef SPR_PRIV_CHECK_EN
    if (sprn[4] && !req_priv) dec_legal_c = 1'b0;
`endif
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (req_fire) state_nx = S_EXEC;
      S_EXEC:  state_nx = S_RESP;
      S_RESP:  if (rsp_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready  = (state == S_IDLE) & ~rst;
    rsp_valid  = (state == S_RESP);
    rsp_data   = (state == S_RESP) ? rsp_data_q : '0;
    rsp_err    = (state == S_RESP) ? rsp_err_q  : 1'b0;
    spr_wr0    = (state == S_EXEC) & mt_q & legal_q & ~is_dec_q;
    spr_waddr0 = spr_wr0 ? idx_q   : '0;
    spr_wd0    = spr_wr0 ? wdata_q : '0;
    spr_raddr0 = ((state == S_EXEC) & ~mt_q & legal_q & ~is_dec_q) ? idx_q : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mt_q       <= 1'b0;
      legal_q    <= 1'b0;
      is_dec_q   <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      if (req_fire) begin
        mt_q     <= req_mt;
        legal_q  <= dec_legal_c;
        is_dec_q <= dec_legal_c && (dec_idx_c == DEC_IDX);
        idx_q    <= dec_idx_c;
        wdata_q  <= req_wdata;
      end
      if (state == S_EXEC) begin
        rsp_err_q <= ~legal_q;
        if (!mt_q && legal_q) rsp_data_q <= is_dec_q ? dec_cnt : spr_rd0;
        else                  rsp_data_q <= '0;
      end
    end
  end

  // DEC: a load from mtspr overrides a coincident decrement and restarts the prescaler.
  assign tick     = (pre_cnt == PRE_MAX);
  assign dec_load = (state == S_EXEC) & mt_q & legal_q & is_dec_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt <= '0;
      dec_cnt <= '0;
      irq_q   <= 1'b0;
      wr1_q   <= 1'b0;
      wd1_q   <= '0;
    end else if (dec_load) begin
      pre_cnt <= '0;
      dec_cnt <= wdata_q;
      irq_q   <= 1'b0;
      wr1_q   <= 1'b1;
      wd1_q   <= wdata_q;
    end else if (tick) begin
      pre_cnt <= '0;
      dec_cnt <= dec_cnt - 1'b1;
      irq_q   <= (dec_cnt == '0);
      wr1_q   <= 1'b1;
      wd1_q   <= dec_cnt - 1'b1;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
      irq_q   <= 1'b0;
      wr1_q   <= 1'b0;
    end
  end

  assign spr_wr1    = wr1_q;
  assign spr_wd1    = wd1_q;
  assign spr_waddr1 = DEC_IDX;
  assign dec_irq    = irq_q;

endmodule
